pc_sequencer: RTL and testbench

- Consumer end of the main control decoder's interface: takes the decoded branch/jump flags plus operand status and produces the architectural PC of the single-cycle MIPS32 core.
- Holds the PC register, resolves all branch and jump types, and supplies the jal link address.
- Halts on a misaligned register-jump target.
- Keeps a saturating count of taken control transfers for debug.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit of a single-cycle MIPS32 core.
//
// Holds the architectural PC, resolves beq/bne/sign-test branches, j/jal and jr,
// supplies the jal link address and keeps a saturating count of taken control
// transfers. A jr to a non-word-aligned target freezes the unit in a sticky
// halt that only reset clears.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             hold PC and counter this cycle
//   instr             current instruction (imm16 = [15:0], target26 = [25:0])
//   Branch, nBranch   beq / bne, qualified by the ALU zero flag
//   BGEZ..BLTZ        sign-test branches on rs_data
//   Jump, jal, jr     unconditional transfers
//   zero, rs_data     operand status
//   pc                current PC (registered)
//   link_addr         pc + 4 (combinational)
//   redirect          1 in the cycle after a taken transfer (registered)
//   halted            sticky misaligned-jr halt (registered)
//   taken_cnt         saturating count of taken transfers (registered)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [31:0]      instr,
  input  logic             Branch,
  input  logic             nBranch,
  input  logic             BGEZ,
  input  logic             BGTZ,
  input  logic             BLEZ,
  input  logic             BLTZ,
  input  logic             Jump,
  input  logic             jal,
  input  logic             jr,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  output logic [31:0]      pc,
  output logic [31:0]      link_addr,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               redirect_q, redirect_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0] pc4, btarget, jtarget, boffset;
  logic        rs_neg, rs_is_zero, br_taken, jr_misaligned;
  logic [31:0] next_pc;
  logic        take;

  // Target arithmetic, all modulo 2^32.
  assign pc4     = pc_q + 32'd4;
  assign boffset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign btarget = pc4 + boffset;
  assign jtarget = {pc4[31:28], instr[25:0], 2'b00};

  assign rs_neg     = rs_data[31];
  assign rs_is_zero = (rs_data == 32'd0);

  assign br_taken = (Branch & zero) | (nBranch & ~zero) |
                    (BGEZ & ~rs_neg) | (BLTZ & rs_neg) |
                    (BGTZ & ~rs_neg & ~rs_is_zero) | (BLEZ & (rs_neg | rs_is_zero));

  assign jr_misaligned = jr & (rs_data[1:0] != 2'b00);

  // Priority jr > j/jal > branch > fall-through. take marks any non-pc4 source,
  // even when the chosen target happens to equal pc4.
  always_comb begin
    next_pc = pc4;
    take    = 1'b0;
    if (jr) begin
      next_pc = rs_data;
      take    = 1'b1;
    end else if (Jump | jal) begin
      next_pc = jtarget;
      take    = 1'b1;
    end else if (br_taken) begin
      next_pc = btarget;
      take    = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (jr_misaligned) begin
            state_d = StHalt;
          end else begin
            pc_d       = next_pc;
            redirect_d = take;
            if (take && (cnt_q != {CNT_W{1'b1}})) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      StHalt: begin
        // Frozen until reset; every input is ignored.
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign link_addr = pc4;
  assign redirect  = redirect_q;
  assign halted    = (state_q == StHalt);
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, Branch, nBranch, BGEZ, BGTZ, BLEZ, BLTZ, Jump, jal, jr, zero;
  logic [31:0] instr, rs_data;

  logic [31:0] pc, link_addr, pc_s, link_s;
  logic        redirect, halted, redirect_s, halted_s;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_s;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr),
    .Branch(Branch), .nBranch(nBranch), .BGEZ(BGEZ), .BGTZ(BGTZ), .BLEZ(BLEZ),
    .BLTZ(BLTZ), .Jump(Jump), .jal(jal), .jr(jr), .zero(zero), .rs_data(rs_data),
    .pc(pc), .link_addr(link_addr), .redirect(redirect), .halted(halted),
    .taken_cnt(taken_cnt)
  );

  pc_sequencer #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr),
    .Branch(Branch), .nBranch(nBranch), .BGEZ(BGEZ), .BGTZ(BGTZ), .BLEZ(BLEZ),
    .BLTZ(BLTZ), .Jump(Jump), .jal(jal), .jr(jr), .zero(zero), .rs_data(rs_data),
    .pc(pc_s), .link_addr(link_s), .redirect(redirect_s), .halted(halted_s),
    .taken_cnt(taken_s)
  );

  typedef struct {
    logic [31:0] pc;
    logic        redirect;
    logic        halted;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  // Reference state, derived from the behavioural description.
  logic [31:0] m_pc = 32'h0000_3000;
  logic        m_halt = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_sat = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_flags();
    stall = 0; Branch = 0; nBranch = 0; BGEZ = 0; BGTZ = 0; BLEZ = 0; BLTZ = 0;
    Jump = 0; jal = 0; jr = 0; zero = 0; instr = '0; rs_data = '0;
  endtask

  // Predict one clock of behaviour, push it, clock, then pop and compare.
  task automatic step();
    exp_t        e;
    logic [31:0] pc4, bt, jt, nxt;
    logic        taken, red;
    pc4 = m_pc + 32'd4;
    chk("link_addr", link_addr, pc4);
    red = 1'b0;
    if (!m_halt && !stall) begin
      bt = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      jt = {pc4[31:28], instr[25:0], 2'b00};
      taken = (Branch && zero) || (nBranch && !zero) || (BGEZ && !rs_data[31]) ||
              (BLTZ && rs_data[31]) || (BGTZ && !rs_data[31] && rs_data != 0) ||
              (BLEZ && (rs_data[31] || rs_data == 0));
      if (jr && rs_data[1:0] != 2'b00) begin
        m_halt = 1'b1;
      end else begin
        if (jr) begin nxt = rs_data; red = 1; end
        else if (Jump || jal) begin nxt = jt; red = 1; end
        else if (taken) begin nxt = bt; red = 1; end
        else nxt = pc4;
        m_pc = nxt;
        if (red) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
          if (m_sat != 2'b11) m_sat = m_sat + 1;
        end
      end
    end
    e.pc = m_pc; e.redirect = red; e.halted = m_halt; e.cnt = m_cnt; e.sat = m_sat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("pc", pc, e.pc);
    chk("redirect", {31'd0, redirect}, {31'd0, e.redirect});
    chk("halted", {31'd0, halted}, {31'd0, e.halted});
    chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.cnt});
    chk("sat_cnt", {30'd0, taken_s}, {30'd0, e.sat});
  endtask

  task automatic jump_to(input logic [31:0] addr);
    clear_flags(); jr = 1; rs_data = addr;
    step();
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #1;
    m_pc = 32'h0000_3000; m_halt = 0; m_cnt = '0; m_sat = '0;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    clear_flags();
    #12;
    apply_reset();

    // Fall-through after reset.
    step(); chk("seq0", pc, 32'h0000_3004);
    step(); chk("seq1", pc, 32'h0000_3008);
    step(); chk("seq2", pc, 32'h0000_300C);
    step(); chk("seq3", pc, 32'h0000_3010);

    // beq taken backwards, then not taken.
    clear_flags(); Branch = 1; zero = 1; instr = 32'h0000_FFFC;
    step(); chk("beq_t", pc, 32'h0000_3004); chk("beq_t_cnt", {16'd0, taken_cnt}, 32'd1);
    jump_to(32'h0000_3010);
    clear_flags(); Branch = 1; zero = 0; instr = 32'h0000_FFFC;
    step(); chk("beq_nt", pc, 32'h0000_3014);

    // bne taken.
    clear_flags(); nBranch = 1; zero = 0; instr = 32'h0000_0001;
    step(); chk("bne_t", pc, 32'h0000_301C);

    // Sign-test branches on rs.
    jump_to(32'h0000_3014);
    clear_flags(); BGTZ = 1; rs_data = 32'd0; instr = 32'h0000_0002;
    step(); chk("bgtz_0", pc, 32'h0000_3018);
    clear_flags(); BGTZ = 1; rs_data = 32'd5; instr = 32'h0000_0002;
    step(); chk("bgtz_5", pc, 32'h0000_3024);
    clear_flags(); BLEZ = 1; rs_data = 32'h8000_0000; instr = 32'h0000_0004;
    step(); chk("blez_neg", pc, 32'h0000_3038);
    clear_flags(); BGEZ = 1; rs_data = 32'h8000_0000; instr = 32'h0000_0004;
    step(); chk("bgez_nt", pc, 32'h0000_303C);
    clear_flags(); BLTZ = 1; rs_data = 32'hFFFF_FFFF; instr = 32'h0000_0000;
    step(); chk("bltz_t", pc, 32'h0000_3040); chk("bltz_red", {31'd0, redirect}, 32'd1);

    // jal with link address, then Jump beating a taken branch.
    jump_to(32'h0000_3020);
    clear_flags(); jal = 1; instr = 32'h0000_0100;
    chk("jal_link", link_addr, 32'h0000_3024);
    step(); chk("jal_pc", pc, 32'h0000_0400);
    clear_flags(); Jump = 1; Branch = 1; zero = 1; instr = 32'h0000_0200;
    step(); chk("j_prio", pc, 32'h0000_0800);
    clear_flags(); jr = 1; Jump = 1; rs_data = 32'h0000_5000; instr = 32'h0000_0200;
    step(); chk("jr_prio", pc, 32'h0000_5000);

    // Stall holds everything and clears redirect.
    for (int i = 0; i < 2; i++) begin
      clear_flags(); stall = 1; Branch = 1; zero = 1; instr = 32'h0000_0010;
      step(); chk("stall_pc", pc, 32'h0000_5000);
    end

    // Misaligned jr halts; nothing moves afterwards.
    clear_flags(); jr = 1; rs_data = 32'h0000_3102;
    step(); chk("halt_pc", pc, 32'h0000_5000); chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      clear_flags();
      stall = $urandom_range(0, 1); Jump = $urandom_range(0, 1); jr = $urandom_range(0, 1);
      Branch = 1; zero = 1; rs_data = $urandom & 32'hFFFF_FFFC; instr = $urandom;
      step(); chk("halt_frozen", pc, 32'h0000_5000);
    end
    chk("halt_link", link_addr, 32'h0000_5004);

    // Asynchronous reset exits halt.
    clear_flags();
    apply_reset();
    step(); chk("post_rst", pc, 32'h0000_3004);

    // PC wrap, then counter saturation on the narrow instance.
    jump_to(32'hFFFF_FFFC);
    clear_flags();
    chk("wrap_link", link_addr, 32'h0000_0000);
    step(); chk("wrap_pc", pc, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      clear_flags(); Jump = 1; instr = 32'h0000_0040;
      step();
    end
    chk("sat_final", {30'd0, taken_s}, 32'd3);
    chk("cnt_final", {16'd0, taken_cnt}, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
